// File: rtl/mux_arb_pkg.sv
// Shared constants, state encoding and helpers for the 4-way round-robin
// arbiter that drives the select lines of mux_4to1.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Index of the set bit in a one-hot (or zero) vector; zero maps to 0.
  function automatic logic [SEL_W-1:0] onehot2idx(input logic [NUM_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux_4to1_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo 4 (rotate, fixed-priority, un-rotate).
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [NUM_REQ-1:0] rot;
  logic [SEL_W-1:0]   off;

  // rot[0] is the requester at ptr, so the lowest set bit is the winner.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    assign rot[gi] = req[ptr + SEL_W'(gi)];
  end

  always_comb begin
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign found = |rot;
  assign idx   = off + ptr;

endmodule

// File: rtl/mux_4to1_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 mux: one-hot grant plus registered
// select lines, with grants released on request drop or hold-limit expiry.
module mux_4to1_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int MAX_HOLD = 8,
  localparam int CNT_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               s1,
  output logic               s0,
  output logic               valid,
  output logic               busy
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t             state_reg, state_next;
  logic [SEL_W-1:0]   ptr_reg, ptr_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [SEL_W-1:0]   sel_reg, sel_next;
  logic               valid_reg, valid_next;
  logic               busy_reg, busy_next;

  logic [SEL_W-1:0]   owner;
  logic               release_grant;
  logic [SEL_W-1:0]   pick_ptr;
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;

  assign owner         = onehot2idx(grant_reg);
  assign release_grant = (state_reg == ST_GRANT) && (!req[owner] || (cnt_reg == HOLD_LAST));
  // Re-arbitration on release already sees the advanced pointer, so the
  // outgoing owner is lowest priority in the same cycle.
  assign pick_ptr      = release_grant ? owner + SEL_W'(1) : ptr_reg;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    grant_next = grant_reg;
    sel_next   = sel_reg;
    valid_next = valid_reg;
    busy_next  = busy_reg;

    if (state_reg == ST_IDLE) begin
      if (pick_found) begin
        state_next           = ST_GRANT;
        grant_next           = '0;
        grant_next[pick_idx] = 1'b1;
        sel_next             = pick_idx;
        valid_next           = 1'b1;
        busy_next            = 1'b1;
        cnt_next             = '0;
      end
    end else begin
      if (release_grant) begin
        ptr_next = pick_ptr;
        if (pick_found) begin
          grant_next           = '0;
          grant_next[pick_idx] = 1'b1;
          sel_next             = pick_idx;
          cnt_next             = '0;
        end else begin
          // Select stays on the last owner so the mux sees no extra toggle.
          state_next = ST_IDLE;
          grant_next = '0;
          valid_next = 1'b0;
          busy_next  = 1'b0;
        end
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      grant_reg <= '0;
      sel_reg   <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      grant_reg <= grant_next;
      sel_reg   <= sel_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
    end
  end

  assign grant = grant_reg;
  assign s1    = sel_reg[1];
  assign s0    = sel_reg[0];
  assign valid = valid_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_mux_4to1_rr_arbiter.sv
// Bench for the round-robin mux arbiter: MAX_HOLD=8 and MAX_HOLD=1 instances
// checked against an owner/pointer/held-cycles reference model.
module tb_mux_4to1_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] req1 = '0;
  logic [3:0] grant, grant1;
  logic       s1, s0, valid, busy;
  logic       s1_1, s0_1, valid1, busy1;
  logic [7:0] obs0, obs1;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per instance: owner (-1 = none), pointer, grant cycles held,
  // last granted index.
  int m_owner[2];
  int m_ptr[2];
  int m_held[2];
  int m_sel[2];
  int m_hold[2] = '{8, 1};

  always #5 clk = ~clk;

  mux_4to1_rr_arbiter #(.MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant),
    .s1(s1), .s0(s0), .valid(valid), .busy(busy)
  );

  mux_4to1_rr_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .grant(grant1),
    .s1(s1_1), .s0(s0_1), .valid(valid1), .busy(busy1)
  );

  assign obs0 = {grant, s1, s0, valid, busy};
  assign obs1 = {grant1, s1_1, s0_1, valid1, busy1};

  function automatic int pick(logic [3:0] r, int p);
    for (int j = 0; j < 4; j++) begin
      if (r[(p + j) % 4]) return (p + j) % 4;
    end
    return -1;
  endfunction

  function automatic void model_step(int k, logic [3:0] r, logic rs);
    int w;
    if (rs) begin
      m_owner[k] = -1; m_ptr[k] = 0; m_held[k] = 0; m_sel[k] = 0;
    end else if (m_owner[k] < 0) begin
      w = pick(r, m_ptr[k]);
      if (w >= 0) begin
        m_owner[k] = w; m_held[k] = 1; m_sel[k] = w;
      end
    end else if (!r[m_owner[k]] || m_held[k] == m_hold[k]) begin
      m_ptr[k] = (m_owner[k] + 1) % 4;
      w = pick(r, m_ptr[k]);
      m_owner[k] = w;
      if (w >= 0) begin
        m_held[k] = 1; m_sel[k] = w;
      end
    end else begin
      m_held[k]++;
    end
  endfunction

  function automatic logic [7:0] exp_vec(int k);
    logic [7:0] v;
    int s;
    s = m_sel[k];
    v = '0;
    if (m_owner[k] >= 0) v[7:4] = 4'(1 << m_owner[k]);
    v[3:2] = s[1:0];
    v[1]   = (m_owner[k] >= 0);
    v[0]   = (m_owner[k] >= 0);
    return v;
  endfunction

  task automatic advance();
    @(posedge clk);
    model_step(0, req, rst);
    model_step(1, req1, rst);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'hF; req1 = 4'hF;
    for (int n = 0; n < 2; n++) begin
      advance();
      n_checks++;
      if (obs0 !== 8'h00) begin
        n_fail++; $display("FAIL reset h8 cyc %0d: got %b want %b", n, obs0, 8'h00);
      end
      n_checks++;
      if (obs1 !== 8'h00) begin
        n_fail++; $display("FAIL reset h1 cyc %0d: got %b want %b", n, obs1, 8'h00);
      end
    end
  endtask

  task automatic test_single();
    rst = 1'b0; req = 4'b0100;
    for (int n = 1; n <= 20; n++) begin
      advance();
      n_checks++;
      if (obs0 !== 8'b0100_10_11) begin
        n_fail++; $display("FAIL single cyc %0d: got %b want %b", n, obs0, 8'b0100_10_11);
      end
      n_checks++;
      if (obs0 !== exp_vec(0)) begin
        n_fail++; $display("FAIL single_model cyc %0d: got %b want %b", n, obs0, exp_vec(0));
      end
    end
  endtask

  task automatic test_rotation();
    logic [7:0] e;
    int o;
    rst = 1'b1; advance();
    rst = 1'b0; req = 4'hF;
    for (int n = 1; n <= 40; n++) begin
      advance();
      o = ((n - 1) / 8) % 4;
      e = {4'(1 << o), o[1:0], 2'b11};
      n_checks++;
      if (obs0 !== e) begin
        n_fail++; $display("FAIL rotation cyc %0d: got %b want %b", n, obs0, e);
      end
      n_checks++;
      if (obs0 !== exp_vec(0)) begin
        n_fail++; $display("FAIL rotation_model cyc %0d: got %b want %b", n, obs0, exp_vec(0));
      end
    end
  endtask

  task automatic test_early_release();
    rst = 1'b1; advance();
    rst = 1'b0; req = 4'b0010; advance();
    req = 4'b1010; advance(); advance();
    n_checks++;
    if (obs0 !== 8'b0010_01_11) begin
      n_fail++; $display("FAIL early_owner1: got %b want %b", obs0, 8'b0010_01_11);
    end
    req = 4'b1000; advance();
    n_checks++;
    if (obs0 !== 8'b1000_11_11) begin
      n_fail++; $display("FAIL early_release: got %b want %b", obs0, 8'b1000_11_11);
    end
    req = 4'b0000; advance();
    n_checks++;
    if (obs0 !== 8'b0000_11_00) begin
      n_fail++; $display("FAIL drop_to_idle: got %b want %b", obs0, 8'b0000_11_00);
    end
    n_checks++;
    if (obs0 !== exp_vec(0)) begin
      n_fail++; $display("FAIL early_model: got %b want %b", obs0, exp_vec(0));
    end
  endtask

  task automatic test_reset_mid_grant();
    rst = 1'b1; advance();
    rst = 1'b0; req = 4'b0100;
    repeat (5) advance();
    n_checks++;
    if (obs0 !== 8'b0100_10_11) begin
      n_fail++; $display("FAIL midrst_pre: got %b want %b", obs0, 8'b0100_10_11);
    end
    rst = 1'b1; req = 4'hF; advance();
    n_checks++;
    if (obs0 !== 8'h00) begin
      n_fail++; $display("FAIL midrst_reset: got %b want %b", obs0, 8'h00);
    end
    rst = 1'b0; advance();
    n_checks++;
    if (obs0 !== 8'b0001_00_11) begin
      n_fail++; $display("FAIL midrst_first: got %b want %b", obs0, 8'b0001_00_11);
    end
  endtask

  task automatic test_hold_one();
    logic [7:0] e;
    int o;
    rst = 1'b1; advance();
    rst = 1'b0; req1 = 4'b1010;
    for (int n = 1; n <= 10; n++) begin
      advance();
      o = (n % 2 == 1) ? 1 : 3;
      e = {4'(1 << o), o[1:0], 2'b11};
      n_checks++;
      if (obs1 !== e) begin
        n_fail++; $display("FAIL hold_one cyc %0d: got %b want %b", n, obs1, e);
      end
      n_checks++;
      if (obs1 !== exp_vec(1)) begin
        n_fail++; $display("FAIL hold_one_model cyc %0d: got %b want %b", n, obs1, exp_vec(1));
      end
    end
  endtask

  task automatic test_random();
    rst = 1'b1; advance();
    rst = 1'b0;
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      // Sticky requests so grants often run into the hold limit.
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
        if ($urandom_range(0, 3) == 0) req1[b] = ~req1[b];
      end
      advance();
      n_checks++;
      if (obs0 !== exp_vec(0)) begin
        n_fail++; $display("FAIL random_h8 cyc %0d req %b: got %b want %b", n, req, obs0, exp_vec(0));
      end
      n_checks++;
      if (obs1 !== exp_vec(1)) begin
        n_fail++; $display("FAIL random_h1 cyc %0d req %b: got %b want %b", n, req1, obs1, exp_vec(1));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1; m_ptr[k] = 0; m_held[k] = 0; m_sel[k] = 0;
    end
    @(negedge clk);
    test_reset();
    test_single();
    test_rotation();
    test_early_release();
    test_reset_mid_grant();
    test_hold_one();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
